// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e       : FSM state encoding (idle / shifting / result-ready)
//   DefaultWidth  : default binary operand width in bits
//   DefaultDigits : default number of BCD output digits
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth  = 10;
  localparam int unsigned DefaultDigits = 4;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or more, so that the
// following left shift carries correctly into the next decimal digit.
//   digit_i : working BCD digit before correction
//   digit_o : corrected digit (modulo 16, no carry out)
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit
// per clock. A conversion takes WIDTH shift cycles plus one result cycle.
//   Clock : rising-edge clock
//   Reset : synchronous active-high reset
//   Start : conversion request, only honoured while idle
//   Bin   : unsigned operand, captured when Start is accepted
//   Busy  : high while shifting
//   Done  : one-cycle pulse when Bcd holds a new result
//   Bcd   : packed BCD result, digit 0 in [3:0]; holds the last completed value
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned DIGITS = DefaultDigits
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      Bin,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   Bcd
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned BcdW = 4 * DIGITS;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   work_q, work_d;
  logic [BcdW-1:0]   work_adj;
  logic [BcdW-1:0]   work_shift;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              last_shift;

  // Per-digit add-3 correction applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (work_q[4*g +: 4]),
      .digit_o (work_adj[4*g +: 4])
    );
  end

  // Shift {BCD, binary} left by one: binary MSB enters BCD bit 0.
  assign work_shift = {work_adj[BcdW-2:0], bin_q[WIDTH-1]};
  assign last_shift = (cnt_q == CntW'(WIDTH - 1));

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Start) state_d = StShift;
      StShift: if (last_shift) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    Busy = (state_q == StShift);
    Done = (state_q == StDone);
  end

  // Datapath next-state.
  always_comb begin
    bin_d  = bin_q;
    work_d = work_q;
    cnt_d  = cnt_q;
    bcd_d  = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          bin_d  = Bin;
          work_d = '0;
          cnt_d  = '0;
        end
      end
      StShift: begin
        work_d = work_shift;
        bin_d  = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + CntW'(1);
        // Only the final working value is ever published.
        if (last_shift) begin
          bcd_d = work_shift;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      bin_q  <= '0;
      work_q <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
    end else begin
      bin_q  <= bin_d;
      work_q <= work_d;
      cnt_q  <= cnt_d;
      bcd_q  <= bcd_d;
    end
  end

  assign Bcd = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [9:0]  Bin;
  logic        Busy;
  logic        Done;
  logic [15:0] Bcd;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [9:0]  bin;
    logic [15:0] bcd;
  } vec_t;

  vec_t vecs[8];

  bin_to_bcd_seq #(.WIDTH(10), .DIGITS(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .Bin   (Bin),
    .Busy  (Busy),
    .Done  (Done),
    .Bcd   (Bcd)
  );

  always #5 Clock = ~Clock;

  // Reference: decimal digits of the operand by plain arithmetic.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [15:0] x);
    for (int d = 0; d < 4; d++) begin
      if (x[4*d +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One conversion; Bin is scrambled during SHIFT to show it is not re-sampled.
  task automatic run_conv(input logic [9:0] b, output logic [15:0] got, output int busy_n,
                          output logic ok, output logic held);
    logic [15:0] prev;
    int n;
    @(negedge Clock);
    prev  = Bcd;
    Start = 1'b1;
    Bin   = b;
    @(negedge Clock);
    Start  = 1'b0;
    Bin    = 10'($urandom);
    busy_n = 0;
    n      = 0;
    held   = 1'b1;
    while (!Done && n < 40) begin
      if (Busy) busy_n++;
      if (Bcd !== prev) held = 1'b0;
      @(negedge Clock);
      n++;
    end
    ok  = Done;
    got = Bcd;
  endtask

  task automatic conv_check(input string name, input logic [9:0] b, input logic [15:0] exp,
                            input logic full);
    logic [15:0] got;
    int          busy_n;
    logic        ok;
    logic        held;
    run_conv(b, got, busy_n, ok, held);
    check({name, " done_seen"}, 32'(ok), 32'd1);
    check({name, " bcd"}, 32'(got), 32'(exp));
    if (full) begin
      check({name, " digits_le_9"}, 32'(digits_ok(got)), 32'd1);
      check({name, " busy_cycles"}, 32'(busy_n), 32'd10);
      check({name, " bcd_held"}, 32'(held), 32'd1);
      @(negedge Clock);
      check({name, " done_one_cycle"}, 32'(Done), 32'd0);
      check({name, " busy_after"}, 32'(Busy), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] cap;
    int          dones;
    int          cyc;
    int          last;
    int          v;

    vecs[0] = '{bin: 10'd0,    bcd: 16'h0000};
    vecs[1] = '{bin: 10'd1023, bcd: 16'h1023};
    vecs[2] = '{bin: 10'd999,  bcd: 16'h0999};
    vecs[3] = '{bin: 10'd10,   bcd: 16'h0010};
    vecs[4] = '{bin: 10'd5,    bcd: 16'h0005};
    vecs[5] = '{bin: 10'd9,    bcd: 16'h0009};
    vecs[6] = '{bin: 10'd512,  bcd: 16'h0512};
    vecs[7] = '{bin: 10'd100,  bcd: 16'h0100};

    Reset = 1'b1;
    Start = 1'b1;
    Bin   = 10'd123;
    repeat (3) @(negedge Clock);
    check("reset busy", 32'(Busy), 32'd0);
    check("reset done", 32'(Done), 32'd0);
    check("reset bcd", 32'(Bcd), 32'd0);
    Start = 1'b0;
    Reset = 1'b0;
    @(negedge Clock);
    check("idle busy", 32'(Busy), 32'd0);

    // Zero operand: 10 busy cycles, Done on the 11th.
    conv_check("zero", 10'd0, 16'h0000, 1'b1);

    foreach (vecs[i]) begin
      conv_check($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, 1'b1);
    end

    // Start re-pulsed with a new operand during SHIFT must be ignored.
    @(negedge Clock);
    Start = 1'b1;
    Bin   = 10'd500;
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    Start = 1'b1;
    Bin   = 10'd7;
    @(negedge Clock);
    Start = 1'b0;
    dones = 0;
    cap   = '0;
    for (int i = 0; i < 30; i++) begin
      if (Done) begin
        dones++;
        cap = Bcd;
      end
      @(negedge Clock);
    end
    check("ignore_start dones", 32'(dones), 32'd1);
    check("ignore_start bcd", 32'(cap), 32'h0500);
    check("ignore_start busy", 32'(Busy), 32'd0);

    // Reset after 5 shifts aborts with no Done.
    Start = 1'b1;
    Bin   = 10'd777;
    @(negedge Clock);
    Start = 1'b0;
    repeat (5) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort busy", 32'(Busy), 32'd0);
    check("abort done", 32'(Done), 32'd0);
    check("abort bcd", 32'(Bcd), 32'd0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (Done) dones++;
      @(negedge Clock);
    end
    check("abort no_done", 32'(dones), 32'd0);
    conv_check("after_reset", 10'd42, 16'h0042, 1'b1);

    // Start held high: back-to-back conversions every WIDTH+2 cycles.
    @(negedge Clock);
    Start = 1'b1;
    Bin   = 10'd321;
    cyc   = 0;
    dones = 0;
    last  = 0;
    while (dones < 4 && cyc < 100) begin
      @(negedge Clock);
      cyc++;
      if (Done) begin
        if (dones > 0) check("b2b period", 32'(cyc - last), 32'd12);
        check("b2b bcd", 32'(Bcd), 32'h0321);
        last = cyc;
        dones++;
      end
    end
    Start = 1'b0;
    check("b2b pulses", 32'(dones), 32'd4);
    repeat (2) @(negedge Clock);
    check("b2b idle", 32'(Busy), 32'd0);

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 200; i++) begin
      v = int'($urandom_range(0, 1023));
      conv_check($sformatf("rand %0d", v), 10'(v), ref_bcd(v), (i % 20) == 0);
    end

    // Exhaustive sweep.
    for (int k = 0; k < 1024; k++) begin
      logic [15:0] got;
      int          busy_n;
      logic        ok;
      logic        held;
      run_conv(10'(k), got, busy_n, ok, held);
      check($sformatf("sweep %0d bcd", k), 32'(got), 32'(ref_bcd(k)));
      check($sformatf("sweep %0d digits", k), 32'(digits_ok(got)), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter WIDTH, default 10, is the binary input width in bits.
REQ-002 Parameter DIGITS, default 4, is the number of BCD output digits; it SHALL satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 Port Clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port Start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-006 Port Bin, input, WIDTH bits: unsigned binary operand, captured on the edge that accepts Start.
REQ-007 Port Busy, output, 1 bit: high while a conversion is in progress (SHIFT state).
REQ-008 Port Done, output, 1 bit: one-cycle pulse marking a new, valid Bcd.
REQ-009 Port Bcd, output, 4*DIGITS bits: packed BCD result, digit 0 in [3:0], most significant digit at top; each digit is 0-9.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-011 IDLE with Start=1 at edge k: capture Bin into the working binary register, clear the working BCD register and the shift counter, go to SHIFT.
REQ-012 IDLE with Start=0: remain in IDLE with all registers held.
REQ-013 Each SHIFT edge SHALL perform one double-dabble step: add 3 to each working BCD digit >= 5, then shift {BCD, binary} left 1 bit, then increment the counter.
REQ-014 The Nth shift (N = WIDTH) SHALL occur at edge k+WIDTH; on that edge Bcd SHALL load the final working BCD value and the state SHALL go to DONE.
REQ-015 Busy SHALL be 1 from after edge k through edge k+WIDTH, i.e. for exactly WIDTH cycles.
REQ-016 Done SHALL be 1 only in DONE, for exactly one cycle after edge k+WIDTH; DONE SHALL return to IDLE on the next edge unconditionally.
REQ-017 Start SHALL be ignored in SHIFT and DONE; a changing Bin during SHIFT SHALL NOT affect the result.
REQ-018 With Start held high continuously, conversions SHALL start back-to-back, one every WIDTH+2 cycles.
REQ-019 Bcd SHALL hold its last completed value until the next DONE; it SHALL never show intermediate working values.
REQ-020 The counter SHALL be ceil(log2(WIDTH+1)) bits wide; add-3 correction SHALL be modulo-16 per digit, with no carry between digits before the shift.
REQ-021 Correct results SHALL hold for Bin = 0 and Bin = 2^WIDTH-1.

Reset
REQ-022 Reset=1 at any edge SHALL force IDLE and set Busy=0, Done=0, Bcd=0, and the working registers and counter to 0, overriding Start.
REQ-023 Reset asserted mid-conversion SHALL abort it with no Done pulse; the first Start accepted after Reset deasserts SHALL convert normally.

Structure
REQ-024 A shared package SHALL hold the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the WIDTH/DIGITS default constants.
REQ-025 The per-digit add-3 correction SHALL be one sub-module, bcd_digit_adj (4-bit in, 4-bit out), instantiated DIGITS times via generate.
REQ-026 The block SHALL be fully synchronous with no latches; Busy and Done SHALL be decoded from the state register.

Verification
REQ-027 Bin=0, Start pulse -> Busy high for 10 cycles, Done pulse on cycle 11, Bcd=16'h0000.
REQ-028 Bin=1023 -> Bcd=16'h1023; Bin=999 -> Bcd=16'h0999; Bin=10 -> Bcd=16'h0010.
REQ-029 Start with Bin=500; during SHIFT set Bin=7 and pulse Start again -> a single Done, Bcd=16'h0500, no second conversion.
REQ-030 Reset pulsed after 5 shifts of Bin=777 -> Busy=0, Done=0, Bcd=0 next cycle, no Done pulse; then Bin=42 Start -> Bcd=16'h0042.
REQ-031 Start held high with Bin=321 -> Done pulses every 12 cycles, Bcd=16'h0321 each time.
REQ-032 Exhaustive sweep of Bin 0..1023 -> every Bcd digit <= 9 and Bcd equals the decimal value of Bin.
